// File: rtl/ct_ifu_icache_tag_arb_pkg.sv
// Shared definitions for the I-cache tag-array arbiter: FSM encoding, tag word layout and field offsets.
package ct_ifu_icache_tag_arb_pkg;

    localparam int unsigned TAG_W    = 28;
    localparam int unsigned WAY_W    = TAG_W + 1;
    localparam int unsigned WORD_W   = 2 * WAY_W + 1;
    localparam int unsigned INDEX_W  = 16;
    localparam int unsigned SET_NUM  = 256;
    localparam int unsigned SET_LSB  = 5;
    localparam int unsigned WEN_W    = 3;

    localparam int unsigned LRU_BIT  = 58;
    localparam int unsigned WAY1_MSB = 57;
    localparam int unsigned WAY1_LSB = 29;
    localparam int unsigned WAY0_MSB = 28;
    localparam int unsigned WAY0_LSB = 0;

    // Active-low field write enables: [2] LRU, [1] way1, [0] way0
    localparam logic [WEN_W-1:0] WEN_NONE      = 3'b111;
    localparam logic [WEN_W-1:0] WEN_ALL       = 3'b000;
    localparam logic [WEN_W-1:0] WEN_REFILL_W0 = 3'b010;
    localparam logic [WEN_W-1:0] WEN_REFILL_W1 = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } inv_state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } way_entry_t;

    typedef struct packed {
        logic       lru;
        way_entry_t way1;
        way_entry_t way0;
    } tag_word_t;

    function automatic way_entry_t way_of(input logic [WORD_W-1:0] word, input logic way);
        if (way) begin
            return way_entry_t'(word[WAY1_MSB:WAY1_LSB]);
        end
        return way_entry_t'(word[WAY0_MSB:WAY0_LSB]);
    endfunction

endpackage

// File: rtl/ct_ifu_icache_tag_arb_tag_cmp.sv
// Per-way hit compare of one tag array entry against the registered fetch tag.
module ct_ifu_icache_tag_cmp
    import ct_ifu_icache_tag_arb_pkg::*;
(
    input  logic             vld,
    input  way_entry_t       entry,
    input  logic [TAG_W-1:0] tag,
    output logic             hit
);

    assign hit = vld & entry.valid & (entry.tag == tag);

endmodule

// File: rtl/ct_ifu_icache_tag_arb.sv
// I-cache tag-array arbiter: invalidate sweep, refill writes and fetch lookups with hit detect.
// Optional fetch anti-starvation guard enabled by defining CT_IFU_TAG_ARB_STARVE_GUARD_EN.
module ct_ifu_icache_tag_arb
    import ct_ifu_icache_tag_arb_pkg::*;
#(
    parameter int unsigned IDX_W      = 8,
    parameter int unsigned STARVE_MAX = 4
)
(
    input  logic                forever_cpuclk,
    input  logic                cpurst,
    input  logic                fetch_req,
    input  logic [INDEX_W-1:0]  fetch_index,
    input  logic [TAG_W-1:0]    fetch_tag,
    output logic                fetch_gnt,
    input  logic                refill_req,
    input  logic                refill_way,
    input  logic [INDEX_W-1:0]  refill_index,
    input  logic [TAG_W-1:0]    refill_tag,
    output logic                refill_gnt,
    input  logic                cp0_inv_req,
    output logic                inv_busy,
    output logic                inv_done,
    output logic                tag_cen_b,
    output logic [WEN_W-1:0]    tag_wen,
    output logic [INDEX_W-1:0]  tag_index,
    output logic [WORD_W-1:0]   tag_din,
    output logic                tag_clk_en,
    input  logic [WORD_W-1:0]   tag_dout,
    output logic                rd_vld,
    output logic [1:0]          hit_way,
    output logic                rd_lru
);

    localparam logic [IDX_W-1:0] SWEEP_LAST = {IDX_W{1'b1}};

    inv_state_e         state;
    logic [IDX_W-1:0]   sweep_cnt;
    logic [INDEX_W-1:0] sweep_index;
    logic               arb_en;
    logic               force_fetch;
    logic [TAG_W-1:0]   fetch_tag_q;
    tag_word_t          din_word;
    way_entry_t         way0_entry;
    way_entry_t         way1_entry;

    // Invalidate-all sequencer; a reset mid-sweep simply drops back to IDLE
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state     <= ST_IDLE;
            sweep_cnt <= '0;
            inv_busy  <= 1'b0;
            inv_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cp0_inv_req) begin
                        state     <= ST_SWEEP;
                        sweep_cnt <= '0;
                        inv_busy  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    sweep_cnt <= sweep_cnt + IDX_W'(1);
                    if (sweep_cnt == SWEEP_LAST) begin
                        state    <= ST_DONE;
                        inv_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    inv_busy <= 1'b0;
                    inv_done <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    inv_busy <= 1'b0;
                    inv_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef CT_IFU_TAG_ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_CW = $clog2(STARVE_MAX + 1);

    logic [STARVE_CW-1:0] starve_cnt;

    // Counts refill wins over a waiting fetch; cleared once fetch is served or withdrawn
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            starve_cnt <= '0;
        end else if (!fetch_req || fetch_gnt) begin
            starve_cnt <= '0;
        end else if (refill_gnt) begin
            starve_cnt <= starve_cnt + STARVE_CW'(1);
        end
    end

    assign force_fetch = fetch_req && (starve_cnt >= STARVE_CW'(STARVE_MAX));
`else
    logic unused_starve_max;

    assign unused_starve_max = (STARVE_MAX == 0);
    assign force_fetch       = 1'b0;
`endif

    // Single-grant arbitration, only while the sequencer is idle
    always_comb begin
        arb_en     = (state == ST_IDLE) && !cpurst;
        refill_gnt = arb_en && refill_req && !force_fetch;
        fetch_gnt  = arb_en && fetch_req && !refill_gnt;
    end

    always_comb begin
        sweep_index                     = '0;
        sweep_index[SET_LSB +: IDX_W]   = sweep_cnt;
    end

    // Tag array port mux: sweep write, refill write, fetch read, or idle
    always_comb begin
        tag_cen_b = 1'b1;
        tag_wen   = WEN_NONE;
        tag_index = '0;
        din_word  = '0;
        if (state == ST_SWEEP) begin
            tag_cen_b = 1'b0;
            tag_wen   = WEN_ALL;
            tag_index = sweep_index;
        end else if (refill_gnt) begin
            tag_cen_b    = 1'b0;
            tag_wen      = refill_way ? WEN_REFILL_W1 : WEN_REFILL_W0;
            tag_index    = refill_index;
            din_word.lru = ~refill_way;
            if (refill_way) begin
                din_word.way1 = way_entry_t'({1'b1, refill_tag});
            end else begin
                din_word.way0 = way_entry_t'({1'b1, refill_tag});
            end
        end else if (fetch_gnt) begin
            tag_cen_b = 1'b0;
            tag_index = fetch_index;
        end
    end

    assign tag_din    = din_word;
    assign tag_clk_en = ~tag_cen_b;

    // Lookup pipeline: compare tag captured alongside the array read
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rd_vld      <= 1'b0;
            fetch_tag_q <= '0;
        end else begin
            rd_vld <= fetch_gnt;
            if (fetch_gnt) begin
                fetch_tag_q <= fetch_tag;
            end
        end
    end

    assign way0_entry = way_of(tag_dout, 1'b0);
    assign way1_entry = way_of(tag_dout, 1'b1);

    ct_ifu_icache_tag_cmp u_cmp_way0 (
        .vld   (rd_vld),
        .entry (way0_entry),
        .tag   (fetch_tag_q),
        .hit   (hit_way[0])
    );

    ct_ifu_icache_tag_cmp u_cmp_way1 (
        .vld   (rd_vld),
        .entry (way1_entry),
        .tag   (fetch_tag_q),
        .hit   (hit_way[1])
    );

    assign rd_lru = rd_vld & tag_dout[LRU_BIT];

endmodule

// File: tb/tb_ct_ifu_icache_tag_arb.sv
// Directed self-checking bench for ct_ifu_icache_tag_arb (guard scenario under CT_IFU_TAG_ARB_STARVE_GUARD_EN).
module tb_ct_ifu_icache_tag_arb;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [15:0] fetch_index;
    logic [27:0] fetch_tag;
    logic        fetch_gnt;
    logic        refill_req;
    logic        refill_way;
    logic [15:0] refill_index;
    logic [27:0] refill_tag;
    logic        refill_gnt;
    logic        cp0_inv_req;
    logic        inv_busy;
    logic        inv_done;
    logic        tag_cen_b;
    logic [2:0]  tag_wen;
    logic [15:0] tag_index;
    logic [58:0] tag_din;
    logic        tag_clk_en;
    logic [58:0] tag_dout;
    logic        rd_vld;
    logic [1:0]  hit_way;
    logic        rd_lru;

    int errors = 0;
    int checks = 0;

    ct_ifu_icache_tag_arb #(.IDX_W(8), .STARVE_MAX(4)) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .fetch_req      (fetch_req),
        .fetch_index    (fetch_index),
        .fetch_tag      (fetch_tag),
        .fetch_gnt      (fetch_gnt),
        .refill_req     (refill_req),
        .refill_way     (refill_way),
        .refill_index   (refill_index),
        .refill_tag     (refill_tag),
        .refill_gnt     (refill_gnt),
        .cp0_inv_req    (cp0_inv_req),
        .inv_busy       (inv_busy),
        .inv_done       (inv_done),
        .tag_cen_b      (tag_cen_b),
        .tag_wen        (tag_wen),
        .tag_index      (tag_index),
        .tag_din        (tag_din),
        .tag_clk_en     (tag_clk_en),
        .tag_dout       (tag_dout),
        .rd_vld         (rd_vld),
        .hit_way        (hit_way),
        .rd_lru         (rd_lru)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst = 1'b1; fetch_req = 1'b1; refill_req = 1'b1; cp0_inv_req = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            obs = {fetch_gnt, refill_gnt, tag_cen_b, tag_clk_en, tag_wen, inv_busy, inv_done, rd_vld, hit_way, rd_lru};
            checks++;
            if (obs !== 13'b0_0_1_0_111_0_0_0_00_0) begin
                errors++; $display("FAIL reset_outputs[%0d] got=%b exp=%b", i, obs, 13'b0_0_1_0_111_0_0_0_00_0);
            end
            checks++;
            if (tag_din !== 59'd0) begin
                errors++; $display("FAIL reset_din[%0d] got=%h exp=0", i, tag_din);
            end
            tick();
        end
        fetch_req = 1'b0; refill_req = 1'b0; cp0_inv_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({tag_cen_b, tag_wen, tag_clk_en} !== 5'b1_111_0) begin
            errors++; $display("FAIL idle_after_reset got=%b exp=%b", {tag_cen_b, tag_wen, tag_clk_en}, 5'b1_111_0);
        end
        tick();
    endtask

    task automatic test_fetch();
        // Fetch hit on way0
        fetch_req = 1'b1; fetch_index = 16'h0040; fetch_tag = 28'h1234567;
        #1;
        checks++;
        if ({fetch_gnt, refill_gnt, tag_cen_b, tag_clk_en, tag_wen} !== 7'b1_0_0_1_111) begin
            errors++; $display("FAIL fetch_grant got=%b exp=%b", {fetch_gnt, refill_gnt, tag_cen_b, tag_clk_en, tag_wen}, 7'b1_0_0_1_111);
        end
        checks++;
        if (tag_index !== 16'h0040 || tag_din !== 59'd0) begin
            errors++; $display("FAIL fetch_index got=%h din=%h exp=0040 din=0", tag_index, tag_din);
        end
        tick();
        // Second fetch back-to-back; changing fetch_tag must not disturb the first compare
        fetch_index = 16'h1FE0; fetch_tag = 28'h0ABCDEF;
        tag_dout = {1'b1, 1'b0, 28'h1234567, 1'b1, 28'h1234567};
        #1;
        checks++;
        if ({rd_vld, hit_way, rd_lru} !== 4'b1_01_1) begin
            errors++; $display("FAIL hit_way0 got=%b exp=%b", {rd_vld, hit_way, rd_lru}, 4'b1_01_1);
        end
        checks++;
        if (fetch_gnt !== 1'b1 || tag_index !== 16'h1FE0) begin
            errors++; $display("FAIL fetch_b2b gnt=%b idx=%h exp gnt=1 idx=1fe0", fetch_gnt, tag_index);
        end
        tick();
        fetch_req = 1'b0;
        tag_dout = {1'b0, 1'b1, 28'h0ABCDEF, 1'b1, 28'h0ABCDE0};
        #1;
        checks++;
        if ({rd_vld, hit_way, rd_lru} !== 4'b1_10_0) begin
            errors++; $display("FAIL hit_way1 got=%b exp=%b", {rd_vld, hit_way, rd_lru}, 4'b1_10_0);
        end
        tick();
        checks++;
        if ({rd_vld, hit_way, rd_lru} !== 4'b0_00_0) begin
            errors++; $display("FAIL rd_idle_gating got=%b exp=%b", {rd_vld, hit_way, rd_lru}, 4'b0_00_0);
        end
        // Miss: both ways valid with other tags
        fetch_req = 1'b1; fetch_index = 16'h0100; fetch_tag = 28'h7777777;
        tick();
        fetch_req = 1'b0;
        tag_dout = {1'b1, 1'b1, 28'h7777776, 1'b1, 28'h6777777};
        #1;
        checks++;
        if ({rd_vld, hit_way, rd_lru} !== 4'b1_00_1) begin
            errors++; $display("FAIL miss got=%b exp=%b", {rd_vld, hit_way, rd_lru}, 4'b1_00_1);
        end
        tick();
        tag_dout = '0;
    endtask

    task automatic test_refill();
        fetch_req = 1'b1; fetch_index = 16'h0040; fetch_tag = 28'h1111111;
        refill_req = 1'b1; refill_way = 1'b1; refill_index = 16'h1FE0; refill_tag = 28'hABCDEF1;
        #1;
        checks++;
        if ({fetch_gnt, refill_gnt, tag_cen_b, tag_clk_en, tag_wen} !== 7'b0_1_0_1_001) begin
            errors++; $display("FAIL refill_w1_grant got=%b exp=%b", {fetch_gnt, refill_gnt, tag_cen_b, tag_clk_en, tag_wen}, 7'b0_1_0_1_001);
        end
        checks++;
        if (tag_index !== 16'h1FE0 || tag_din !== {1'b0, 1'b1, 28'hABCDEF1, 29'd0}) begin
            errors++; $display("FAIL refill_w1_data idx=%h din=%h exp idx=1fe0 din=%h", tag_index, tag_din, {1'b0, 1'b1, 28'hABCDEF1, 29'd0});
        end
        tick();
        fetch_req = 1'b0;
        refill_way = 1'b0; refill_index = 16'h0020; refill_tag = 28'h5555555;
        #1;
        checks++;
        if ({rd_vld, fetch_gnt, refill_gnt, tag_cen_b, tag_wen} !== 7'b0_0_1_0_010) begin
            errors++; $display("FAIL refill_w0_grant got=%b exp=%b", {rd_vld, fetch_gnt, refill_gnt, tag_cen_b, tag_wen}, 7'b0_0_1_0_010);
        end
        checks++;
        if (tag_index !== 16'h0020 || tag_din !== {1'b1, 29'd0, 1'b1, 28'h5555555}) begin
            errors++; $display("FAIL refill_w0_data idx=%h din=%h exp idx=0020 din=%h", tag_index, tag_din, {1'b1, 29'd0, 1'b1, 28'h5555555});
        end
        tick();
        refill_req = 1'b0;
        #1;
        checks++;
        if ({fetch_gnt, refill_gnt, tag_cen_b, tag_clk_en, tag_wen} !== 7'b0_0_1_0_111 || tag_din !== 59'd0) begin
            errors++; $display("FAIL idle_port got=%b din=%h exp=%b din=0", {fetch_gnt, refill_gnt, tag_cen_b, tag_clk_en, tag_wen}, tag_din, 7'b0_0_1_0_111);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [15:0] exp_idx;
        // Pulse together with a refill: refill wins this cycle, sweep starts next
        cp0_inv_req = 1'b1; refill_req = 1'b1; refill_way = 1'b0; refill_index = 16'h0100; refill_tag = 28'h0000123;
        #1;
        checks++;
        if ({refill_gnt, tag_wen, inv_busy} !== 5'b1_010_0) begin
            errors++; $display("FAIL inv_with_refill got=%b exp=%b", {refill_gnt, tag_wen, inv_busy}, 5'b1_010_0);
        end
        tick();
        cp0_inv_req = 1'b0; refill_req = 1'b0; fetch_req = 1'b1; fetch_index = 16'h0040;
        for (int k = 0; k < 256; k++) begin
            cp0_inv_req = (k == 50);
            exp_idx = 16'(k) << 5;
            #1;
            checks++;
            if ({fetch_gnt, refill_gnt, tag_cen_b, tag_wen, inv_busy, inv_done} !== 8'b0_0_0_000_1_0
                || tag_index !== exp_idx || tag_din !== 59'd0) begin
                errors++;
                $display("FAIL sweep[%0d] ctl=%b idx=%h din=%h exp ctl=%b idx=%h din=0", k,
                         {fetch_gnt, refill_gnt, tag_cen_b, tag_wen, inv_busy, inv_done}, tag_index, tag_din,
                         8'b0_0_0_000_1_0, exp_idx);
            end
            tick();
        end
        cp0_inv_req = 1'b0;
        #1;
        checks++;
        if ({inv_busy, inv_done, fetch_gnt, tag_cen_b} !== 4'b1_1_0_1) begin
            errors++; $display("FAIL inv_done_cycle got=%b exp=%b", {inv_busy, inv_done, fetch_gnt, tag_cen_b}, 4'b1_1_0_1);
        end
        tick();
        checks++;
        if ({inv_busy, inv_done, fetch_gnt} !== 3'b0_0_1) begin
            errors++; $display("FAIL after_done got=%b exp=%b", {inv_busy, inv_done, fetch_gnt}, 3'b0_0_1);
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int bad;
        cp0_inv_req = 1'b1;
        tick();
        cp0_inv_req = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        checks++;
        if (tag_index !== 16'h0C80 || inv_busy !== 1'b1) begin
            errors++; $display("FAIL sweep_at_100 idx=%h busy=%b exp idx=0c80 busy=1", tag_index, inv_busy);
        end
        rst = 1'b1; fetch_req = 1'b1; fetch_index = 16'h0040;
        #1;
        checks++;
        if ({fetch_gnt, refill_gnt, tag_cen_b, tag_clk_en, tag_wen, inv_busy, inv_done, rd_vld} !== 10'b0_0_1_0_111_0_0_0) begin
            errors++; $display("FAIL mid_sweep_reset got=%b exp=%b",
                               {fetch_gnt, refill_gnt, tag_cen_b, tag_clk_en, tag_wen, inv_busy, inv_done, rd_vld}, 10'b0_0_1_0_111_0_0_0);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({fetch_gnt, tag_cen_b, inv_busy} !== 3'b1_0_0 || tag_index !== 16'h0040) begin
            errors++; $display("FAIL fetch_after_release got=%b idx=%h exp=%b idx=0040", {fetch_gnt, tag_cen_b, inv_busy}, tag_index, 3'b1_0_0);
        end
        tick();
        fetch_req = 1'b0;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            if (inv_busy !== 1'b0 || inv_done !== 1'b0 || tag_wen !== 3'b111) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL sweep_resumed bad_cycles=%0d exp=0", bad);
        end
    endtask

    task automatic test_priority();
        logic [1:0] exp_g;
        refill_req = 1'b1; fetch_req = 1'b1; refill_way = 1'b1; refill_index = 16'h0060; refill_tag = 28'h0000042;
        fetch_index = 16'h0080;
        for (int c = 0; c < 10; c++) begin
`ifdef CT_IFU_TAG_ARB_STARVE_GUARD_EN
            exp_g = (c % 5 == 4) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            #1;
            checks++;
            if ({fetch_gnt, refill_gnt} !== exp_g) begin
                errors++; $display("FAIL priority[%0d] got fetch/refill=%b exp=%b", c, {fetch_gnt, refill_gnt}, exp_g);
            end
            tick();
        end
        refill_req = 1'b0; fetch_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_index = '0; fetch_tag = '0;
        refill_req = 1'b0; refill_way = 1'b0; refill_index = '0; refill_tag = '0;
        cp0_inv_req = 1'b0; tag_dout = '0;
        test_reset();
        test_fetch();
        test_refill();
        test_sweep();
        test_reset_mid_sweep();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
